// File: rtl/pulse_monitor_if.sv
// Pulse monitor signal bundle: strobe/clear inputs and all status outputs.
// The master side drives pulse_i/clear_i; the slave side is the monitor itself.
interface pulse_monitor_if #(
    parameter int EXPECTED_PERIOD = 10,
    parameter int TOLERANCE       = 1
);
    localparam int CNT_BITS = $clog2(EXPECTED_PERIOD + TOLERANCE + 2);

    logic                pulse_i;
    logic                clear_i;
    logic                locked_o;
    logic                early_o;
    logic                missing_o;
    logic [CNT_BITS-1:0] period_o;
    logic                period_valid_o;
    logic [7:0]          error_count_o;

    modport master (
        output pulse_i, clear_i,
        input  locked_o, early_o, missing_o, period_o, period_valid_o, error_count_o
    );

    modport slave (
        input  pulse_i, clear_i,
        output locked_o, early_o, missing_o, period_o, period_valid_o, error_count_o
    );
endinterface

// File: rtl/pulse_monitor.sv
// Pulse monitor: measures the interval between strobes on pulse_i, checks it
// against EXPECTED_PERIOD +/- TOLERANCE, and locks after LOCK_COUNT
// consecutive good intervals. Early and missing strobes are flagged.
// Optional feature macro: PULSE_MONITOR_ERRCNT_EN builds the 8-bit saturating
// error counter; without it error_count_o is tied to zero.
module pulse_monitor #(
    parameter int EXPECTED_PERIOD = 10,
    parameter int TOLERANCE       = 1,
    parameter int LOCK_COUNT      = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    pulse_monitor_if.slave mon
);
    localparam int CNT_BITS  = $clog2(EXPECTED_PERIOD + TOLERANCE + 2);
    localparam int GOOD_BITS = $clog2(LOCK_COUNT + 1);

    // Shortest good interval, last cycle of the window, and counter ceiling.
    localparam logic [CNT_BITS-1:0]  WIN_LO      = CNT_BITS'(EXPECTED_PERIOD - TOLERANCE);
    localparam logic [CNT_BITS-1:0]  WIN_LAST    = CNT_BITS'(EXPECTED_PERIOD + TOLERANCE);
    localparam logic [CNT_BITS-1:0]  CNT_MAX     = '1;
    localparam logic [GOOD_BITS-1:0] GOOD_TARGET = GOOD_BITS'(LOCK_COUNT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic [GOOD_BITS-1:0] good_q, good_d;
    logic [GOOD_BITS-1:0] good_inc;
    logic [CNT_BITS-1:0]  period_q, period_d;
    logic                 locked_q, locked_d;
    logic                 early_q, early_d;
    logic                 missing_q, missing_d;
    logic                 pv_q, pv_d;

    assign good_inc = good_q + 1'b1;

    // Next-state, interval measurement and strobe decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        good_d    = good_q;
        period_d  = period_q;
        early_d   = 1'b0;
        missing_d = 1'b0;
        pv_d      = 1'b0;

        if (mon.clear_i) begin
            // Clear wins over a coincident strobe; the last period is kept.
            state_d = HUNT;
            cnt_d   = '0;
            good_d  = '0;
        end else begin
            case (state_q)
                HUNT: begin
                    // First event only establishes a reference; nothing is measured.
                    if (mon.pulse_i) begin
                        state_d = TRACK;
                        cnt_d   = CNT_BITS'(1);
                        good_d  = '0;
                    end
                end
                TRACK, LOCKED: begin
                    if (mon.pulse_i) begin
                        period_d = cnt_q;
                        pv_d     = 1'b1;
                        cnt_d    = CNT_BITS'(1);
                        if (cnt_q < WIN_LO) begin
                            // Early: this event becomes the new reference.
                            early_d = 1'b1;
                            state_d = TRACK;
                            good_d  = '0;
                        end else if (state_q == TRACK) begin
                            good_d = good_inc;
                            if (good_inc == GOOD_TARGET) begin
                                state_d = LOCKED;
                            end
                        end
                    end else if (cnt_q == WIN_LAST) begin
                        // Window closes this edge with no event: the counter
                        // would reach EXPECTED_PERIOD+TOLERANCE+1.
                        missing_d = 1'b1;
                        state_d   = HUNT;
                        good_d    = '0;
                    end
                end
                default: begin
                    state_d = HUNT;
                    good_d  = '0;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= HUNT;
            cnt_q     <= '0;
            good_q    <= '0;
            period_q  <= '0;
            locked_q  <= 1'b0;
            early_q   <= 1'b0;
            missing_q <= 1'b0;
            pv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            good_q    <= good_d;
            period_q  <= period_d;
            locked_q  <= locked_d;
            early_q   <= early_d;
            missing_q <= missing_d;
            pv_q      <= pv_d;
        end
    end

`ifdef PULSE_MONITOR_ERRCNT_EN
    logic [7:0] err_q, err_d;

    // Early and missing are never raised together, so one increment suffices.
    always_comb begin
        err_d = err_q;
        if (mon.clear_i) begin
            err_d = '0;
        end else if ((early_d || missing_d) && (err_q != 8'hFF)) begin
            err_d = err_q + 1'b1;
        end
    end

    // Saturating error counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign mon.error_count_o = err_q;
`else
    assign mon.error_count_o = 8'd0;
`endif

    assign mon.locked_o       = locked_q;
    assign mon.early_o        = early_q;
    assign mon.missing_o      = missing_q;
    assign mon.period_o       = period_q;
    assign mon.period_valid_o = pv_q;

endmodule

// File: tb/tb_pulse_monitor.sv
// Testbench for pulse_monitor: directed scenarios plus randomized strobe
// intervals, checked cycle by cycle through an expectation queue against an
// event-time reference model.
`timescale 1ns/1ps
module tb_pulse_monitor;
    localparam int EP       = 10;
    localparam int TOL      = 1;
    localparam int LC       = 4;
    localparam int CNT_BITS = $clog2(EP + TOL + 2);

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    pulse_monitor_if #(.EXPECTED_PERIOD(EP), .TOLERANCE(TOL)) bus ();

    pulse_monitor #(
        .EXPECTED_PERIOD(EP),
        .TOLERANCE      (TOL),
        .LOCK_COUNT     (LC)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .mon    (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic                locked;
        logic                early;
        logic                missing;
        logic                pv;
        logic [CNT_BITS-1:0] period;
        logic [7:0]          errs;
    } obs_t;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: absolute edge numbers, no notion of a counter register.
    int m_k;
    bit m_has_ref;
    int m_ref;
    int m_streak;
    bit m_locked;
    int m_period;
    int m_errs;

    function automatic obs_t observe();
        obs_t o;
        o.locked  = bus.locked_o;
        o.early   = bus.early_o;
        o.missing = bus.missing_o;
        o.pv      = bus.period_valid_o;
        o.period  = bus.period_o;
        o.errs    = bus.error_count_o;
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got lock=%0b early=%0b miss=%0b pv=%0b period=%0d err=%0d, want lock=%0b early=%0b miss=%0b pv=%0b period=%0d err=%0d",
                     name, $time, act.locked, act.early, act.missing, act.pv, act.period, act.errs,
                     exp.locked, exp.early, exp.missing, exp.pv, exp.period, exp.errs);
        end
    endtask

    task automatic model_reset();
        m_k       = 0;
        m_has_ref = 1'b0;
        m_ref     = 0;
        m_streak  = 0;
        m_locked  = 1'b0;
        m_period  = 0;
        m_errs    = 0;
    endtask

    // Predict the outputs following the clock edge that samples (p, c).
    task automatic model_step(input bit p, input bit c);
        obs_t e;
        bit   early   = 1'b0;
        bit   missing = 1'b0;
        bit   pv      = 1'b0;
        int   n;
        m_k++;
        if (c) begin
            m_has_ref = 1'b0;
            m_locked  = 1'b0;
            m_streak  = 0;
            m_errs    = 0;
        end else if (!m_has_ref) begin
            if (p) begin
                m_has_ref = 1'b1;
                m_ref     = m_k;
                m_streak  = 0;
            end
        end else begin
            n = m_k - m_ref;
            if (p) begin
                pv       = 1'b1;
                m_period = n;
                m_ref    = m_k;
                if (n < EP - TOL) begin
                    early    = 1'b1;
                    m_streak = 0;
                    m_locked = 1'b0;
                    if (m_errs < 255) m_errs++;
                end else begin
                    m_streak++;
                    if (m_streak >= LC) m_locked = 1'b1;
                end
            end else if (n >= EP + TOL) begin
                // Any later event could only be out of window.
                missing   = 1'b1;
                m_has_ref = 1'b0;
                m_locked  = 1'b0;
                m_streak  = 0;
                if (m_errs < 255) m_errs++;
            end
        end
        e.locked  = m_locked;
        e.early   = early;
        e.missing = missing;
        e.pv      = pv;
        e.period  = CNT_BITS'(m_period);
`ifdef PULSE_MONITOR_ERRCNT_EN
        e.errs    = 8'(m_errs);
`else
        e.errs    = 8'd0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic tick(input bit p, input bit c);
        @(negedge clock);
        bus.pulse_i = p;
        bus.clear_i = c;
        model_step(p, c);
    endtask

    // Event n cycles after the previous stimulus cycle that carried one.
    task automatic interval(input int n);
        for (int i = 1; i < n; i++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    task automatic async_reset(input int hold);
        @(posedge clock);
        #3;
        reset_n     = 1'b0;
        bus.pulse_i = 1'b0;
        bus.clear_i = 1'b0;
        #1 check_obs("reset_immediate", observe(), '0);
        repeat (hold) @(posedge clock);
        #1 check_obs("reset_held", observe(), '0);
        @(posedge clock);
        #3 reset_n = 1'b1;
        model_reset();
    endtask

    // Scoreboard monitor: one expectation per sampled edge.
    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) check_obs("scoreboard", observe(), exp_q.pop_front());
    end

    initial begin
        int r;
        bus.pulse_i = 1'b0;
        bus.clear_i = 1'b0;
        model_reset();

        // Power-on reset.
        repeat (3) @(posedge clock);
        #1 check_obs("reset_state", observe(), '0);
        @(posedge clock);
        #3 reset_n = 1'b1;

        // Lock on a clean 10-cycle stream, then one early interval and relock.
        tick(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) interval(10);
        interval(7);
        for (int i = 0; i < 5; i++) interval(10);

        // Strobes stop while locked: a single missing strobe, then silence.
        idle(40);

        // Edges of the window are good; one cycle beyond is missing.
        tick(1'b1, 1'b0);
        interval(9);
        interval(11);
        interval(9);
        interval(11);
        interval(11);
        interval(12);
        interval(10);

        // Continuously high strobe: every cycle is an early event.
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);

        // Drive the error count into saturation.
        for (int i = 0; i < 300; i++) interval(3);

        // Clear with a coincident strobe, then confirm HUNT ignores silence.
        tick(1'b1, 1'b1);
        idle(25);

        // Randomized intervals with occasional clears.
        tick(1'b1, 1'b0);
        for (int e = 0; e < 250; e++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4)       tick(1'($urandom_range(0, 1)), 1'b1);
            else if (r < 70) interval(int'($urandom_range(EP - TOL, EP + TOL)));
            else             interval(int'($urandom_range(1, EP + TOL + 4)));
        end

        // Lock, reset mid-interval, then relock from scratch.
        tick(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) interval(10);
        idle(4);
        async_reset(3);
        tick(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) interval(10);
        idle(15);

        // Let the monitor consume the last expectations.
        repeat (3) @(posedge clock);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pulse_monitor.md
PULSE_MONITOR -- requirements
Module: pulse_monitor

Interface
REQ-001 Parameter EXPECTED_PERIOD, default 10, nominal cycles between strobes (>= 2).
REQ-002 Parameter TOLERANCE, default 1, allowed +/- deviation in cycles (< EXPECTED_PERIOD).
REQ-003 Parameter LOCK_COUNT, default 4, consecutive good intervals required to lock (>= 1).
REQ-004 Localparam CNT_BITS SHALL be $clog2(EXPECTED_PERIOD+TOLERANCE+2).
REQ-005 clock  input  1  single clock; all logic on posedge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 pulse_i  input  1  synchronous strobe; each cycle sampled high is one event.
REQ-008 clear_i  input  1  synchronous clear of state and error count.
REQ-009 locked_o  output  1  high while in LOCKED state.
REQ-010 early_o  output  1  one-cycle strobe: interval shorter than window.
REQ-011 missing_o  output  1  one-cycle strobe: no event within window.
REQ-012 period_o  output  CNT_BITS  last measured interval in cycles.
REQ-013 period_valid_o  output  1  one-cycle strobe: period_o updated.
REQ-014 error_count_o  output  8  saturating count of early plus missing events.

Function
REQ-015 Interval counter SHALL count cycles since the last accepted event; events at cycles t and t+N measure N; the counter saturates at its maximum value.
REQ-016 Window: good iff EXPECTED_PERIOD-TOLERANCE <= N <= EXPECTED_PERIOD+TOLERANCE; early iff N < EXPECTED_PERIOD-TOLERANCE.
REQ-017 States: HUNT (no reference), TRACK (reference held, good_count < LOCK_COUNT), LOCKED.
REQ-018 HUNT: an event SHALL move to TRACK with good_count=0; no interval check, no period_valid_o.
REQ-019 TRACK/LOCKED: every event SHALL load period_o with N, pulse period_valid_o, and restart the counter.
REQ-020 TRACK: a good event increments good_count; reaching LOCK_COUNT moves to LOCKED.
REQ-021 TRACK/LOCKED: an early event pulses early_o, increments the error count, and enters TRACK with good_count=0, using this event as the new reference.
REQ-022 TRACK/LOCKED: if the counter reaches EXPECTED_PERIOD+TOLERANCE+1 with no event in that cycle, the block pulses missing_o once, increments the error count, and enters HUNT.
REQ-023 HUNT SHALL NOT raise missing_o or early_o.
REQ-024 All outputs are registered; strobes assert the cycle after the clock edge that samples the causing event.
REQ-025 error_count_o saturates at 255; early_o and missing_o are mutually exclusive by construction.
REQ-026 clear_i high forces HUNT, zeroes the counter and error_count_o, and discards a coincident pulse_i; period_o is held.
REQ-027 pulse_i held high continuously is treated as an event every cycle (N=1), i.e. early when EXPECTED_PERIOD-TOLERANCE > 1.

Reset
REQ-028 reset_n low SHALL asynchronously force HUNT, counter=0, good_count=0, period_o=0, error_count_o=0, and all strobes and locked_o to 0.
REQ-029 The block leaves reset on the first clock edge after reset_n rises; reset mid-interval discards that interval.

Configuration
REQ-030 Macro PULSE_MONITOR_ERRCNT_EN: when defined, the 8-bit saturating error counter is built; when undefined, error_count_o is tied to 0 and no counter register exists, and all other behaviour is unchanged.

Verification
REQ-031 Defaults, pulses every 10 cycles -> locked_o rises 1 cycle after the 5th pulse; period_o=10, error_count_o=0.
REQ-032 Locked, next pulse after 7 cycles -> early_o strobe, period_o=7, locked_o low, error_count_o=1; four further 10-cycle intervals -> relock.
REQ-033 Locked, pulses stop -> missing_o once, 12 cycles after the last pulse (edge 11 + 1 registered cycle), state HUNT, no repeat strobes.
REQ-034 Intervals 9, 11, 9, 11 -> all good, lock, no errors; interval 12 -> missing_o, 11 counts 12 never reported.
REQ-035 300 early events with PULSE_MONITOR_ERRCNT_EN -> error_count_o=255; clear_i with coincident pulse_i -> count 0, HUNT, pulse ignored.
REQ-036 reset_n asserted mid-lock, asynchronous to clock -> outputs 0 immediately; after release, lock again after 5 pulses.
